// File: rtl/memtop_mp_if.sv
// rtl/memtop_mp_if.sv - Bus bundle for memtop_mp: region updates, write port, read ports, error counter.
interface memtop_mp_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_RD     = 2,
  parameter int NUM_REG    = 2
);
  localparam int IDX_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

  logic                           ready;
  logic                           perm_req;
  logic [IDX_W-1:0]               perm_idx;
  logic                           perm_en;
  logic [ADDR_WIDTH-1:0]          perm_start;
  logic [ADDR_WIDTH-1:0]          perm_end;
  logic                           wr_req;
  logic [ADDR_WIDTH-1:0]          wr_addr;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic [DATA_WIDTH/8-1:0]        wr_be;
  logic                           wr_ack;
  logic                           wr_err;
  logic [NUM_RD-1:0]              rd_req;
  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0]   rd_data;
  logic [NUM_RD-1:0]              rd_ack;
  logic                           err_clr;
  logic [15:0]                    err_cnt;

  modport master (
    input  ready, wr_ack, wr_err, rd_data, rd_ack, err_cnt,
    output perm_req, perm_idx, perm_en, perm_start, perm_end,
           wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr, err_clr
  );

  modport slave (
    output ready, wr_ack, wr_err, rd_data, rd_ack, err_cnt,
    input  perm_req, perm_idx, perm_en, perm_start, perm_end,
           wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr, err_clr
  );
endinterface

// File: rtl/memtop_mp.sv
// rtl/memtop_mp.sv - Multi-read-port RAM with zero-fill init, byte enables and write-protect regions.
module memtop_mp #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_RD     = 2,
  parameter int NUM_REG    = 2
) (
  input  logic        clk,
  input  logic        rst,
  memtop_mp_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;
  localparam int IDX_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  init_ptr;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic                   reg_en    [NUM_REG];
  logic [ADDR_WIDTH-1:0]  reg_start [NUM_REG];
  logic [ADDR_WIDTH-1:0]  reg_end   [NUM_REG];
  logic                   wr_prot;
  logic                   wr_ok;
  logic                   wr_rej;

  // An inverted region (start > end) can never satisfy both bounds.
  always_comb begin
    wr_prot = 1'b0;
    for (int r = 0; r < NUM_REG; r++) begin
      if (reg_en[r] && (reg_start[r] <= bus.wr_addr) && (bus.wr_addr <= reg_end[r]))
        wr_prot = 1'b1;
    end
  end

  assign wr_ok  = (state == RUN) && bus.wr_req && !wr_prot;
  assign wr_rej = (state == RUN) && bus.wr_req && wr_prot;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[init_ptr] <= '0;
      end else if (wr_ok) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.wr_be[b])
            mem[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      init_ptr    <= '0;
      bus.ready   <= 1'b0;
      bus.wr_ack  <= 1'b0;
      bus.wr_err  <= 1'b0;
      bus.rd_ack  <= '0;
      bus.rd_data <= '0;
      bus.err_cnt <= '0;
      for (int r = 0; r < NUM_REG; r++) begin
        reg_en[r]    <= (r == 0);
        reg_start[r] <= '0;
        reg_end[r]   <= '0;
      end
    end else begin
      bus.wr_ack <= 1'b0;
      bus.wr_err <= 1'b0;
      bus.rd_ack <= '0;
      case (state)
        INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (&init_ptr) begin
            state     <= RUN;
            bus.ready <= 1'b1;
          end
        end
        RUN: begin
          if (bus.wr_req) begin
            bus.wr_ack <= 1'b1;
            bus.wr_err <= wr_prot;
          end
          // Nonblocking reads see the pre-write word when addresses collide.
          for (int p = 0; p < NUM_RD; p++) begin
            if (bus.rd_req[p]) begin
              bus.rd_ack[p] <= 1'b1;
              bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] <= mem[bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
            end
          end
          if (bus.perm_req) begin
            for (int r = 0; r < NUM_REG; r++) begin
              if (bus.perm_idx == IDX_W'(r)) begin
                reg_en[r]    <= bus.perm_en;
                reg_start[r] <= bus.perm_start;
                reg_end[r]   <= bus.perm_end;
              end
            end
          end
        end
        default: state <= INIT;
      endcase
      if (bus.err_clr)
        bus.err_cnt <= '0;
      else if (wr_rej && (bus.err_cnt != 16'hFFFF))
        bus.err_cnt <= bus.err_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_memtop_mp.sv
// tb/tb_memtop_mp.sv - Table-driven and scoreboard bench for memtop_mp.
module tb_memtop_mp;
  localparam int AW = 8, DW = 16, NRD = 2, NREG = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memtop_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_REG(NREG)) bus ();
  memtop_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_REG(NREG)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { int port; logic [DW-1:0] data; } rd_exp_t;
  typedef struct {
    bit wr; int port; logic [AW-1:0] addr; logic [DW-1:0] data;
    logic [1:0] be; logic exp_err; logic [DW-1:0] exp_rd;
  } vec_t;

  rd_exp_t     rd_q[$];
  logic        wr_q[$];
  logic [15:0] err_exp = '0;
  int          n_pass = 0, n_total = 0;
  vec_t        vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clear_inputs();
    bus.perm_req = 1'b0; bus.perm_idx = '0; bus.perm_en = 1'b0;
    bus.perm_start = '0; bus.perm_end = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    bus.rd_req = '0; bus.rd_addr = '0; bus.err_clr = 1'b0;
  endtask

  task automatic drv_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be, input logic exp_err);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
    wr_q.push_back(exp_err);
    if (exp_err && err_exp != 16'hFFFF) err_exp = err_exp + 16'd1;
  endtask

  task automatic drv_rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_exp_t e;
    bus.rd_req[p] = 1'b1;
    bus.rd_addr[p*AW +: AW] = a;
    e.port = p; e.data = exp;
    rd_q.push_back(e);
  endtask

  task automatic drv_perm(input logic idx, input logic en, input logic [AW-1:0] s, input logic [AW-1:0] e);
    bus.perm_req = 1'b1; bus.perm_idx = idx; bus.perm_en = en;
    bus.perm_start = s; bus.perm_end = e;
  endtask

  // One clock: every response queued for this cycle is popped and compared.
  task automatic tick();
    rd_exp_t    e;
    logic [NRD-1:0] exp_ack;
    logic       we;
    exp_ack = '0;
    @(posedge clk); #1;
    while (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      exp_ack[e.port] = 1'b1;
      check($sformatf("rd_data[%0d]", e.port), 32'(bus.rd_data[e.port*DW +: DW]), 32'(e.data));
    end
    check("rd_ack", 32'(bus.rd_ack), 32'(exp_ack));
    if (wr_q.size() > 0) begin
      we = wr_q.pop_front();
      check("wr_ack", 32'(bus.wr_ack), 32'd1);
      check("wr_err", 32'(bus.wr_err), 32'(we));
    end else begin
      check("wr_idle", {30'd0, bus.wr_ack, bus.wr_err}, 32'd0);
    end
    check("err_cnt", 32'(bus.err_cnt), 32'(err_exp));
    clear_inputs();
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.ready) break;
    end
    check(name, n, 256);
  endtask

  initial begin
    int init_acks;
    int n_sat;
    clear_inputs();

    vecs[0]  = '{1'b1, 0, 8'h00, 16'h1234, 2'b11, 1'b1, 16'h0000};
    vecs[1]  = '{1'b0, 0, 8'h00, 16'h0000, 2'b00, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 0, 8'h05, 16'hABCD, 2'b01, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 1, 8'h05, 16'h0000, 2'b00, 1'b0, 16'h00CD};
    vecs[4]  = '{1'b1, 0, 8'h05, 16'h1200, 2'b10, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 0, 8'h05, 16'h0000, 2'b00, 1'b0, 16'h12CD};
    vecs[6]  = '{1'b1, 0, 8'h07, 16'h0001, 2'b11, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 0, 8'hFF, 16'hFFFF, 2'b11, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1, 8'hFF, 16'h0000, 2'b00, 1'b0, 16'hFFFF};
    vecs[9]  = '{1'b1, 0, 8'h01, 16'h00AA, 2'b00, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 0, 8'h01, 16'h0000, 2'b00, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1, 8'h07, 16'h0000, 2'b00, 1'b0, 16'h0001};

    @(posedge clk); #1;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_outputs", {bus.rd_data, 6'd0, bus.rd_ack, bus.wr_ack, bus.wr_err}, 64'd0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);

    // Requests held throughout INIT must all be ignored.
    rst = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 8'h03; bus.wr_data = 16'hFFFF; bus.wr_be = 2'b11;
    bus.rd_req = 2'b11; bus.perm_req = 1'b1; bus.perm_idx = 1'b0; bus.perm_en = 1'b0;
    init_acks = 0;
    begin
      int n;
      n = 0;
      for (int i = 0; i < 1000; i++) begin
        @(posedge clk); #1;
        n++;
        if (bus.wr_ack || bus.rd_ack != 0) init_acks++;
        if (bus.ready) break;
      end
      check("ready_latency", n, 256);
    end
    clear_inputs();
    check("init_ignored", init_acks, 0);

    for (int a = 0; a < 256; a += 2) begin
      drv_rd(0, 8'(a), 16'h0000);
      drv_rd(1, 8'(a + 1), 16'h0000);
      tick();
    end

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) drv_wr(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].exp_err);
      else            drv_rd(vecs[i].port, vecs[i].addr, vecs[i].exp_rd);
      tick();
    end

    // Region update and write in the same cycle: write sees old regions.
    drv_perm(1'b1, 1'b1, 8'h10, 8'h1F);
    drv_wr(8'h12, 16'h5555, 2'b11, 1'b0); tick();
    drv_wr(8'h12, 16'hAAAA, 2'b11, 1'b1); tick();
    drv_wr(8'h10, 16'h1010, 2'b11, 1'b1); tick();
    drv_wr(8'h1F, 16'h1F1F, 2'b11, 1'b1); tick();
    drv_wr(8'h0F, 16'h0F0F, 2'b11, 1'b0); tick();
    drv_wr(8'h20, 16'h2020, 2'b11, 1'b0); tick();
    drv_rd(0, 8'h12, 16'h5555); drv_rd(1, 8'h1F, 16'h0000); tick();

    drv_perm(1'b1, 1'b1, 8'h30, 8'h20); tick();
    drv_wr(8'h25, 16'h2525, 2'b11, 1'b0); tick();
    drv_wr(8'h12, 16'h1212, 2'b11, 1'b0); tick();

    drv_wr(8'h07, 16'hBEEF, 2'b11, 1'b0);
    drv_rd(0, 8'h07, 16'h0001); drv_rd(1, 8'h07, 16'h0001); tick();
    drv_rd(0, 8'h07, 16'hBEEF); drv_rd(1, 8'h07, 16'hBEEF); tick();
    tick();
    check("rd_hold", 32'(bus.rd_data), 32'hBEEFBEEF);

    // Drive rejected writes straight to saturation without per-cycle checks.
    n_sat = 32'hFFFF - int'(err_exp);
    bus.wr_req = 1'b1; bus.wr_addr = 8'h00; bus.wr_data = 16'hDEAD; bus.wr_be = 2'b11;
    repeat (n_sat) @(posedge clk);
    #1;
    clear_inputs();
    err_exp = 16'hFFFF;
    tick();
    drv_wr(8'h00, 16'h0BAD, 2'b11, 1'b1); tick();
    drv_wr(8'h00, 16'h0BAD, 2'b11, 1'b1);
    bus.err_clr = 1'b1; err_exp = 16'h0000;
    tick();
    drv_wr(8'h00, 16'h0BAD, 2'b11, 1'b1); tick();

    // Pending responses dropped by reset, then reset again mid-INIT.
    bus.wr_req = 1'b1; bus.wr_addr = 8'h09; bus.wr_be = 2'b11; bus.rd_req = 2'b11;
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_drop", {bus.rd_data, 6'd0, bus.rd_ack, bus.wr_ack, bus.wr_err}, 64'd0);
    check("rst_run_ready", 32'(bus.ready), 32'd0);
    check("rst_run_err_cnt", 32'(bus.err_cnt), 32'd0);
    err_exp = 16'h0000;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_init_ready", 32'(bus.ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready("restart_latency");

    drv_wr(8'h12, 16'h3333, 2'b11, 1'b0); drv_rd(0, 8'h12, 16'h0000); tick();
    drv_wr(8'h00, 16'h4444, 2'b11, 1'b1); drv_rd(1, 8'h07, 16'h0000); tick();
    drv_rd(0, 8'h12, 16'h3333); drv_rd(1, 8'h00, 16'h0000); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
